// File: rtl/rf_write_buffer_if.sv
// rf_write_buffer_if
//   Bundles the write-request handshake and the register-file write port
//   of rf_write_buffer.
//   Signals:
//     in_valid / in_ready   request handshake (producer -> buffer)
//     in_addr  [4:0]        destination register address
//     in_data  [N:0]        write data
//     rf_hold               register file stalls the drain
//     rf_we / rf_wa / rf_wd register file WE / WA / IN
//   Modports:
//     master  execution-unit / register-file side (drives requests and hold)
//     slave   the buffer itself
interface rf_write_buffer_if #(
  parameter int N = 31
) ();
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_addr;
  logic [N:0] in_data;
  logic       rf_hold;
  logic       rf_we;
  logic [4:0] rf_wa;
  logic [N:0] rf_wd;

  modport master (
    output in_valid, in_addr, in_data, rf_hold,
    input  in_ready, rf_we, rf_wa, rf_wd
  );

  modport slave (
    input  in_valid, in_addr, in_data, rf_hold,
    output in_ready, rf_we, rf_wa, rf_wd
  );
endinterface

// File: rtl/rf_write_buffer.sv
// rf_write_buffer
//   In-order writeback queue in front of the 32-entry register file write
//   port. Requests are accepted over a valid/ready handshake and drained one
//   per cycle onto WE/WA/IN unless the register file asserts hold.
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     wb (slave)        in_valid/in_ready/in_addr/in_data, rf_hold,
//                       rf_we/rf_wa/rf_wd
//     count             occupied entries, 0..DEPTH
//     empty, full       count == 0, count == DEPTH
//     fwd_ra_a/b        read addresses to look up in pending entries
//     fwd_hit_a/b       a pending entry matches
//     fwd_data_a/b      data of the youngest matching entry (0 on miss)
//   Build option:
//     RF_WRITE_BUFFER_FWD_EN  when defined, the fwd_* ports and lookup logic
//                             are present; otherwise they are omitted.
module rf_write_buffer #(
  parameter int N     = 31,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rf_write_buffer_if.slave     wb,
  output logic [AW:0]          count,
  output logic                 empty,
  output logic                 full
`ifdef RF_WRITE_BUFFER_FWD_EN
  ,
  input  logic [4:0]           fwd_ra_a,
  input  logic [4:0]           fwd_ra_b,
  output logic                 fwd_hit_a,
  output logic                 fwd_hit_b,
  output logic [N:0]           fwd_data_a,
  output logic [N:0]           fwd_data_b
`endif
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [4:0]    addr_q [DEPTH];
  logic [N:0]    data_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push, pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);
  assign count = count_q;

  // in_ready depends only on registered occupancy, so rf_hold never reaches it.
  assign wb.in_ready = ~full;
  assign push = wb.in_valid & ~full;
  assign pop  = ~empty & ~wb.rf_hold;

  assign wb.rf_we = pop;
  assign wb.rf_wa = empty ? '0 : addr_q[rd_ptr_q];
  assign wb.rf_wd = empty ? '0 : data_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage is deliberately not reset; occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= wb.in_addr;
      data_q[wr_ptr_q] <= wb.in_data;
    end
  end

`ifdef RF_WRITE_BUFFER_FWD_EN
  // Scan oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    logic [AW-1:0] idx;
    idx        = '0;
    fwd_hit_a  = 1'b0;
    fwd_hit_b  = 1'b0;
    fwd_data_a = '0;
    fwd_data_b = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + AW'(i);
      if (((AW+1)'(i) < count_q) && (addr_q[idx] == fwd_ra_a)) begin
        fwd_hit_a  = 1'b1;
        fwd_data_a = data_q[idx];
      end
      if (((AW+1)'(i) < count_q) && (addr_q[idx] == fwd_ra_b)) begin
        fwd_hit_b  = 1'b1;
        fwd_data_b = data_q[idx];
      end
    end
  end
`endif

endmodule

// File: tb/tb_rf_write_buffer.sv
// tb_rf_write_buffer
//   Directed, table-driven bench for rf_write_buffer plus hand-written
//   sequences for async reset, forwarding and pointer wrap.
module tb_rf_write_buffer;

  localparam int N     = 31;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [AW:0] count;
  logic        empty, full;
`ifdef RF_WRITE_BUFFER_FWD_EN
  logic [4:0]  fwd_ra_a, fwd_ra_b;
  logic        fwd_hit_a, fwd_hit_b;
  logic [N:0]  fwd_data_a, fwd_data_b;
`endif

  rf_write_buffer_if #(.N(N)) bus ();

  rf_write_buffer #(.N(N), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb         (bus.slave),
    .count      (count),
    .empty      (empty),
    .full       (full)
`ifdef RF_WRITE_BUFFER_FWD_EN
    ,
    .fwd_ra_a   (fwd_ra_a),
    .fwd_ra_b   (fwd_ra_b),
    .fwd_hit_a  (fwd_hit_a),
    .fwd_hit_b  (fwd_hit_b),
    .fwd_data_a (fwd_data_a),
    .fwd_data_b (fwd_data_b)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        v;
    logic [4:0]  a;
    logic [31:0] d;
    logic        h;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    int          cnt;
    logic        rdy;
  } vec_t;

  vec_t tbl [25];

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_we"},    32'(bus.rf_we),    32'd0);
    check({tag, "_wa"},    32'(bus.rf_wa),    32'd0);
    check({tag, "_wd"},    bus.rf_wd,         32'd0);
    check({tag, "_count"}, 32'(count),        32'd0);
    check({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_empty"}, 32'(empty),        32'd1);
    check({tag, "_full"},  32'(full),         32'd0);
  endtask

  initial begin
    // {valid, addr, data, hold, exp_we, exp_wa, exp_wd, exp_count, exp_ready}
    tbl[0]  = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd0,  32'h0,        0, 1'b1};
    tbl[1]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 1'b0, 5'd0,  32'h0,        0, 1'b1};
    tbl[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 1, 1'b1};
    tbl[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd0,  32'h0,        0, 1'b1};
    tbl[4]  = '{1'b1, 5'd1,  32'h101,      1'b1, 1'b0, 5'd0,  32'h0,        0, 1'b1};
    tbl[5]  = '{1'b1, 5'd2,  32'h202,      1'b1, 1'b0, 5'd1,  32'h101,      1, 1'b1};
    tbl[6]  = '{1'b1, 5'd3,  32'h303,      1'b1, 1'b0, 5'd1,  32'h101,      2, 1'b1};
    tbl[7]  = '{1'b1, 5'd4,  32'h404,      1'b1, 1'b0, 5'd1,  32'h101,      3, 1'b1};
    tbl[8]  = '{1'b1, 5'd6,  32'h606,      1'b1, 1'b0, 5'd1,  32'h101,      4, 1'b0};
    tbl[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 5'd1,  32'h101,      4, 1'b0};
    tbl[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 5'd2,  32'h202,      3, 1'b1};
    tbl[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 5'd3,  32'h303,      2, 1'b1};
    tbl[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 5'd4,  32'h404,      1, 1'b1};
    tbl[13] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd0,  32'h0,        0, 1'b1};
    tbl[14] = '{1'b1, 5'd10, 32'hA0,       1'b1, 1'b0, 5'd0,  32'h0,        0, 1'b1};
    tbl[15] = '{1'b1, 5'd11, 32'hA1,       1'b1, 1'b0, 5'd10, 32'hA0,       1, 1'b1};
    tbl[16] = '{1'b1, 5'd12, 32'hA2,       1'b1, 1'b0, 5'd10, 32'hA0,       2, 1'b1};
    tbl[17] = '{1'b1, 5'd13, 32'hA3,       1'b1, 1'b0, 5'd10, 32'hA0,       3, 1'b1};
    tbl[18] = '{1'b1, 5'd14, 32'hA4,       1'b0, 1'b1, 5'd10, 32'hA0,       4, 1'b0};
    tbl[19] = '{1'b1, 5'd14, 32'hA4,       1'b0, 1'b1, 5'd11, 32'hA1,       3, 1'b1};
    tbl[20] = '{1'b1, 5'd15, 32'hA5,       1'b0, 1'b1, 5'd12, 32'hA2,       3, 1'b1};
    tbl[21] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 5'd13, 32'hA3,       3, 1'b1};
    tbl[22] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 5'd14, 32'hA4,       2, 1'b1};
    tbl[23] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 5'd15, 32'hA5,       1, 1'b1};
    tbl[24] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd0,  32'h0,        0, 1'b1};

    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_addr  = '0;
    bus.in_data  = '0;
    bus.rf_hold  = 1'b0;
`ifdef RF_WRITE_BUFFER_FWD_EN
    fwd_ra_a = 5'd0;
    fwd_ra_b = 5'd0;
`endif

    // Reset state
    #12;
    check_idle("reset");
`ifdef RF_WRITE_BUFFER_FWD_EN
    check("reset_hit_a",  32'(fwd_hit_a), 32'd0);
    check("reset_data_a", fwd_data_a,     32'd0);
`endif
    rst_n = 1'b1;
    tick();

    // Table-driven vectors: drive, settle, compare, then clock
    for (int i = 0; i < 25; i++) begin
      bus.in_valid = tbl[i].v;
      bus.in_addr  = tbl[i].a;
      bus.in_data  = tbl[i].d;
      bus.rf_hold  = tbl[i].h;
      #1;
      check($sformatf("v%0d_we", i),    32'(bus.rf_we),    32'(tbl[i].we));
      check($sformatf("v%0d_wa", i),    32'(bus.rf_wa),    32'(tbl[i].wa));
      check($sformatf("v%0d_wd", i),    bus.rf_wd,         tbl[i].wd);
      check($sformatf("v%0d_count", i), 32'(count),        32'(tbl[i].cnt));
      check($sformatf("v%0d_ready", i), 32'(bus.in_ready), 32'(tbl[i].rdy));
      check($sformatf("v%0d_empty", i), 32'(empty),        32'(tbl[i].cnt == 0));
      check($sformatf("v%0d_full", i),  32'(full),         32'(tbl[i].cnt == DEPTH));
      tick();
    end
    bus.in_valid = 1'b0;

    // Asynchronous reset mid-traffic
    bus.rf_hold  = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_addr  = 5'd20;
    bus.in_data  = 32'h1234;
    tick();
    bus.in_addr  = 5'd21;
    bus.in_data  = 32'h5678;
    tick();
    bus.in_valid = 1'b0;
    bus.rf_hold  = 1'b0;
    #1;
    check("pre_rst_we",    32'(bus.rf_we), 32'd1);
    check("pre_rst_count", 32'(count),     32'd2);
    rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    tick();
    rst_n = 1'b1;
    tick();
    check_idle("post_rst");

`ifdef RF_WRITE_BUFFER_FWD_EN
    // Forwarding: two writes to address 7, youngest wins
    bus.rf_hold  = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_addr  = 5'd7;
    bus.in_data  = 32'h11;
    tick();
    bus.in_data  = 32'h22;
    tick();
    bus.in_valid = 1'b0;
    fwd_ra_a = 5'd7;
    fwd_ra_b = 5'd9;
    #1;
    check("fwd_hit_a",  32'(fwd_hit_a), 32'd1);
    check("fwd_data_a", fwd_data_a,     32'h22);
    check("fwd_hit_b",  32'(fwd_hit_b), 32'd0);
    check("fwd_data_b", fwd_data_b,     32'd0);
    fwd_ra_b = 5'd7;
    bus.rf_hold = 1'b0;
    #1;
    check("fwd_commit_we",  32'(bus.rf_we), 32'd1);
    check("fwd_commit_hit", 32'(fwd_hit_b), 32'd1);
    check("fwd_commit_dat", fwd_data_b,     32'h22);
    tick();
    check("fwd_last_hit", 32'(fwd_hit_a), 32'd1);
    check("fwd_last_dat", fwd_data_a,     32'h22);
    tick();
    check("fwd_gone_hit", 32'(fwd_hit_a), 32'd0);
    check("fwd_gone_dat", fwd_data_a,     32'd0);
`endif

    // Pointer wrap with random hold, checked against a queue model
    begin
      int          pushed = 0;
      int          drained = 0;
      int          cyc = 0;
      logic        exp_rdy, do_pop, do_push;
      logic [4:0]  pa;
      logic [31:0] pd;
      pa = 5'($urandom_range(0, 31));
      pd = $urandom;
      while ((pushed < 10 || q.size() > 0) && cyc < 200) begin
        bus.in_valid = (pushed < 10);
        bus.in_addr  = pa;
        bus.in_data  = pd;
        bus.rf_hold  = 1'($urandom_range(0, 1));
        #1;
        exp_rdy = (q.size() < DEPTH);
        do_pop  = (q.size() > 0) && !bus.rf_hold;
        do_push = bus.in_valid && exp_rdy;
        check("wrap_ready", 32'(bus.in_ready), 32'(exp_rdy));
        check("wrap_we",    32'(bus.rf_we),    32'(do_pop));
        check("wrap_wa",    32'(bus.rf_wa),    (q.size() > 0) ? 32'(q[0].a) : 32'd0);
        check("wrap_wd",    bus.rf_wd,         (q.size() > 0) ? q[0].d : 32'd0);
        tick();
        if (do_pop) begin
          void'(q.pop_front());
          drained++;
        end
        if (do_push) begin
          q.push_back('{pa, pd});
          pushed++;
          pa = 5'($urandom_range(0, 31));
          pd = $urandom;
        end
        cyc++;
      end
      bus.in_valid = 1'b0;
      bus.rf_hold  = 1'b0;
      check("wrap_drained", 32'(drained), 32'd10);
      check("wrap_empty",   32'(empty),   32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rf_write_buffer.md
# rf_write_buffer

Writeback queue that sits directly upstream of the 32-entry register file's write port. It accepts write requests (address + data) from execution units over a valid/ready handshake and holds them in a small in-order FIFO. It drains one entry per cycle into the register file's WE/WA/IN inputs unless the register file side asserts hold. An optional forwarding lookup lets readers see pending writes that are still buffered and not yet committed.

## Interface
- N, 31: MSB index of the data word (data width N+1), matching the register file.
- DEPTH, 4: number of buffer entries; power of two, at least 2.
- AW, 2: log2(DEPTH).

- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  write request present.
- in_ready  output  1  buffer can accept; equals !full.
- in_addr  input  5  destination register address.
- in_data  input  N+1  write data.
- rf_hold  input  1  register file side stalls the drain.
- rf_we  output  1  write enable to register file (WE).
- rf_wa  output  5  write address to register file (WA).
- rf_wd  output  N+1  write data to register file (IN).
- count  output  AW+1  occupied entries, 0..DEPTH.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- fwd_ra_a, fwd_ra_b  input  5  read addresses to check against pending entries.
- fwd_hit_a, fwd_hit_b  output  1  a pending entry matches the read address.
- fwd_data_a, fwd_data_b  output  N+1  data of the youngest matching entry.

## Operation
- Circular FIFO: write pointer, read pointer (AW bits, natural wrap), count (AW+1 bits).
- Push: in_valid && in_ready at a clock edge stores {in_addr, in_data} at the write pointer, then increments the pointer.
- Pop: !empty && !rf_hold at a clock edge increments the read pointer.
- rf_we = !empty && !rf_hold. rf_wa/rf_wd = head entry when !empty, else 0.
- The register file commits head at the same edge the buffer pops it.
- Push and pop at the same edge: count unchanged and both pointers advance.
- Push when full is not accepted (in_ready low), even if a pop occurs at that edge. No combinational path from rf_hold to in_ready.
- Writes to the same address are kept and drained in arrival order. Address 0 receives no special treatment.
- Forwarding: combinational compare of fwd_ra_x against all occupied entries. The youngest match wins. On no match, hit = 0 and data = 0. The head entry being committed this cycle still counts as a hit, because it remains in the buffer until the edge.

## Timing
- Reset (async assert, sync to clk on deassert is the integrator's job): pointers 0, count 0, empty 1, full 0, in_ready 1, rf_we 0, rf_wa 0, rf_wd 0, fwd_hit_x 0, fwd_data_x 0. Entry storage is not reset.
- Latency: an entry pushed at edge k appears on rf_we/rf_wa/rf_wd in the cycle after edge k. With rf_hold low it commits at edge k+1.
- No bypass: an empty buffer never presents in_data on rf_* in the same cycle.
- Throughput: 1 entry/cycle sustained when push and pop overlap.
- Reset mid-operation: all pending entries are discarded immediately and no rf_we pulse is generated.

## Configuration
- RF_WRITE_BUFFER_FWD_EN defined: fwd_* ports and the comparison logic are present as described.
- Not defined: fwd_ra_a/fwd_ra_b are absent from the port list, and fwd_hit_x/fwd_data_x are absent with no comparators synthesized. All other behaviour is identical.

## Test plan
- Reset then idle: rf_we=0, rf_wa=0, rf_wd=0, count=0, in_ready=1. Assert rst_n low mid-traffic: outputs return to these values without waiting for clk.
- Single push addr 5, data 0xDEADBEEF, rf_hold=0: cycle after push rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF. Next cycle empty=1, rf_we=0.
- rf_hold=1, push 4 entries (addr 1..4): full=1, in_ready=0, and a 5th request is held off. Release hold: rf_wa sequence 1,2,3,4 on four consecutive cycles.
- Full buffer, in_valid=1, hold released: no push at the first pop edge (count 4→3). Push accepted at the next edge. Continuous push/pop afterwards keeps count constant.
- Forwarding (macro on): buffer holds addr 7=0x11 then addr 7=0x22, with fwd_ra_a=7 and fwd_ra_b=9. Required: hit_a=1, data_a=0x22, hit_b=0, data_b=0.
- Pointer wrap: push/pop 10 entries with random hold. Drain order and data match push order across the wrap of both pointers.
